// File: rtl/prog_loader_pkg.sv
// Shared definitions for the programming loader and the instruction memory it fills.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_e;

  // Instruction-memory geometry; the image width is derived here so loader and memory agree.
  localparam int STATE_COUNT   = 8;
  localparam int OUTPUT_WIDTH  = 4;
  localparam int COND_WIDTH    = 2;
  localparam int ACTION_WIDTH  = 3;
  localparam int COUNTER_WIDTH = 8;
  localparam int COUNTER_COUNT = 4;
  localparam int STATE_BITS    = $clog2(STATE_COUNT);
  localparam int WORD_WIDTH    = OUTPUT_WIDTH + COND_WIDTH + ACTION_WIDTH + STATE_BITS;
  localparam int IMEM_WIDTH    = COUNTER_WIDTH * COUNTER_COUNT + STATE_COUNT * WORD_WIDTH + STATE_BITS;

  function automatic int beats_for(input int mem_width, input int input_width);
    return (mem_width + input_width - 1) / input_width;
  endfunction

endpackage

// File: rtl/prog_loader_sync_cell.sv
// Multi-stage synchroniser for an asynchronous input bus with a configurable reset value.
module sync_cell #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_r;

  // Shift chain; the first stage is the only one that may go metastable.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= {STAGES{RESET_VAL}};
    end else begin
      stage_r <= {stage_r[STAGES-2:0], d};
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/prog_loader.sv
// Serial programming front-end: synchronises the pins, frames beats and drives instruction-memory strobes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter  int INPUT_WIDTH = 1,
  parameter  int MEM_WIDTH   = IMEM_WIDTH,
  parameter  int SYNC_STAGES = 2,
  localparam int BEATS       = beats_for(MEM_WIDTH, INPUT_WIDTH),
  localparam int CNT_W       = $clog2(BEATS + 1)
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   pin_sel_n,
  input  logic                   pin_sck,
  input  logic [INPUT_WIDTH-1:0] pin_data,
  output logic                   prog_enable,
  output logic                   prog_advance,
  output logic [INPUT_WIDTH-1:0] prog_data,
  output logic                   loaded,
  output logic                   frame_error,
  output logic                   run_enable,
  output logic [CNT_W-1:0]       beat_count
);

  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                   sel_n_s;
  logic                   sck_s;
  logic [INPUT_WIDTH-1:0] data_s;
  logic                   sck_d_r;
  logic [INPUT_WIDTH-1:0] data_d_r;
  logic                   sck_rise_s;

  loader_state_e          state_r, state_nxt_s;
  logic [CNT_W-1:0]       beat_count_r, count_nxt_s;
  logic                   ovf_r, ovf_nxt_s;
  logic                   loaded_r, loaded_nxt_s;
  logic                   err_r, err_nxt_s;
  logic                   accept_s;
  logic                   pend_r;
  logic                   prog_enable_r;
  logic                   prog_advance_r;
  logic [INPUT_WIDTH-1:0] prog_data_r;

  sync_cell #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
    .clock(clock), .rst_n(rst_n), .d(pin_sel_n), .q(sel_n_s)
  );
  sync_cell #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clock(clock), .rst_n(rst_n), .d(pin_sck), .q(sck_s)
  );
  sync_cell #(.WIDTH(INPUT_WIDTH), .STAGES(SYNC_STAGES), .RESET_VAL({INPUT_WIDTH{1'b0}})) u_sync_data (
    .clock(clock), .rst_n(rst_n), .d(pin_data), .q(data_s)
  );

  assign sck_rise_s = sck_s & ~sck_d_r;

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and frame bookkeeping; a beat coincident with deselect counts before the decision.
  always_comb begin
    state_nxt_s  = state_r;
    count_nxt_s  = beat_count_r;
    ovf_nxt_s    = ovf_r;
    loaded_nxt_s = loaded_r;
    err_nxt_s    = err_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (sck_rise_s) begin
          if (beat_count_r < BEATS_C) begin
            accept_s    = 1'b1;
            count_nxt_s = beat_count_r + CNT_ONE;
          end else begin
            ovf_nxt_s = 1'b1;
          end
        end else begin
          accept_s = 1'b0;
        end
        if (sel_n_s) begin
          if ((count_nxt_s == BEATS_C) && !ovf_nxt_s) begin
            state_nxt_s  = ST_DONE;
            loaded_nxt_s = 1'b1;
          end else begin
            state_nxt_s  = ST_ERROR;
            err_nxt_s    = 1'b1;
            loaded_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (!sel_n_s) begin
          state_nxt_s  = ST_LOAD;
          count_nxt_s  = {CNT_W{1'b0}};
          ovf_nxt_s    = 1'b0;
          loaded_nxt_s = 1'b0;
          err_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and outputs; enable is held over the advance cycle of a beat taken while leaving LOAD.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sck_d_r        <= 1'b0;
      data_d_r       <= {INPUT_WIDTH{1'b0}};
      beat_count_r   <= {CNT_W{1'b0}};
      ovf_r          <= 1'b0;
      loaded_r       <= 1'b0;
      err_r          <= 1'b0;
      pend_r         <= 1'b0;
      prog_enable_r  <= 1'b0;
      prog_advance_r <= 1'b0;
      prog_data_r    <= {INPUT_WIDTH{1'b0}};
    end else begin
      sck_d_r        <= sck_s;
      data_d_r       <= data_s;
      beat_count_r   <= count_nxt_s;
      ovf_r          <= ovf_nxt_s;
      loaded_r       <= loaded_nxt_s;
      err_r          <= err_nxt_s;
      pend_r         <= accept_s;
      prog_enable_r  <= (state_nxt_s == ST_LOAD) | pend_r;
      prog_advance_r <= pend_r;
      if (pend_r) begin
        prog_data_r <= data_d_r;
      end else begin
        prog_data_r <= prog_data_r;
      end
    end
  end

  assign prog_enable  = prog_enable_r;
  assign prog_advance = prog_advance_r;
  assign prog_data    = prog_data_r;
  assign loaded       = loaded_r;
  assign run_enable   = loaded_r;
  assign frame_error  = err_r;
  assign beat_count   = beat_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framing, boundaries, latency and reset behaviour.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic       clock;
  logic       rst_n;
  logic       pin_sel_n;
  logic       pin_sck;
  logic [0:0] pin_data;
  logic       prog_enable;
  logic       prog_advance;
  logic [0:0] prog_data;
  logic       loaded;
  logic       frame_error;
  logic       run_enable;
  logic [7:0] beat_count;

  int         vectors = 0;
  int         errs    = 0;
  int         adv_cnt = 0;
  logic       exp_bits [256];
  logic [130:0] shadow  = '0;
  logic [130:0] exp_img = '0;

  prog_loader dut (
    .clock(clock), .rst_n(rst_n), .pin_sel_n(pin_sel_n), .pin_sck(pin_sck),
    .pin_data(pin_data), .prog_enable(prog_enable), .prog_advance(prog_advance),
    .prog_data(prog_data), .loaded(loaded), .frame_error(frame_error),
    .run_enable(run_enable), .beat_count(beat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction-memory shadow: every advance must carry the driven bit with enable high.
  always @(negedge clock) begin
    if (rst_n && prog_advance) begin
      chk("adv_with_enable", {255'd0, prog_enable}, 256'd1);
      if (adv_cnt < 256) chk("adv_bit", {255'd0, prog_data}, {255'd0, exp_bits[adv_cnt]});
      adv_cnt++;
      shadow = {shadow[129:0], prog_data};
    end
  end

  function automatic logic pattern(input int i, input int variant);
    if (variant == 0) return (i % 4) != 1;
    else return (i % 3) == 0;
  endfunction

  task automatic beat(input logic b);
    pin_data = b;
    repeat (2) @(negedge clock);
    pin_sck = 1'b1;
    repeat (3) @(negedge clock);
    pin_sck = 1'b0;
  endtask

  task automatic run_frame(input int n, input int variant, input bit coincide);
    logic b;
    adv_cnt   = 0;
    exp_img   = '0;
    pin_sel_n = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < n; i++) begin
      b = pattern(i, variant);
      exp_bits[i] = b;
      if (i < 131) exp_img = {exp_img[129:0], b};
      if (coincide && (i == n - 1)) begin
        pin_data = b;
        repeat (2) @(negedge clock);
        pin_sck   = 1'b1;
        pin_sel_n = 1'b1;
        repeat (3) @(negedge clock);
        pin_sck = 1'b0;
      end else begin
        beat(b);
      end
    end
    if (!coincide) begin
      repeat (3) @(negedge clock);
      pin_sel_n = 1'b1;
    end
    repeat (6) @(negedge clock);
  endtask

  initial begin
    rst_n = 1'b0; pin_sel_n = 1'b1; pin_sck = 1'b0; pin_data = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_enable", {255'd0, prog_enable}, 256'd0);
    chk("rst_advance", {255'd0, prog_advance}, 256'd0);
    chk("rst_loaded", {255'd0, loaded}, 256'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_state", {254'd0, dut.state_r}, {254'd0, ST_IDLE});
    chk("idle_count", {248'd0, beat_count}, 256'd0);

    // Full frame, pattern 1,0,1,1,...
    run_frame(131, 0, 1'b0);
    chk("full_adv", adv_cnt, 256'd131);
    chk("full_count", {248'd0, beat_count}, 256'd131);
    chk("full_loaded", {255'd0, loaded}, 256'd1);
    chk("full_run", {255'd0, run_enable}, 256'd1);
    chk("full_err", {255'd0, frame_error}, 256'd0);
    chk("full_image", {125'd0, shadow}, {125'd0, exp_img});
    chk("full_state", {254'd0, dut.state_r}, {254'd0, ST_DONE});

    // New select from DONE: loaded falls within SYNC_STAGES+1 cycles.
    pin_sel_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reselect_loaded", {255'd0, loaded}, 256'd0);
    chk("reselect_enable", {255'd0, prog_enable}, 256'd1);
    pin_sel_n = 1'b1;
    repeat (6) @(negedge clock);

    // Short frame.
    run_frame(130, 0, 1'b0);
    chk("short_adv", adv_cnt, 256'd130);
    chk("short_count", {248'd0, beat_count}, 256'd130);
    chk("short_err", {255'd0, frame_error}, 256'd1);
    chk("short_loaded", {255'd0, loaded}, 256'd0);
    chk("short_run", {255'd0, run_enable}, 256'd0);

    // Overflow frame.
    run_frame(135, 1, 1'b0);
    chk("ovf_adv", adv_cnt, 256'd131);
    chk("ovf_count", {248'd0, beat_count}, 256'd131);
    chk("ovf_err", {255'd0, frame_error}, 256'd1);
    chk("ovf_state", {254'd0, dut.state_r}, {254'd0, ST_ERROR});

    // Last edge coincident with deselect, different image.
    run_frame(131, 1, 1'b1);
    chk("coinc_adv", adv_cnt, 256'd131);
    chk("coinc_count", {248'd0, beat_count}, 256'd131);
    chk("coinc_state", {254'd0, dut.state_r}, {254'd0, ST_DONE});
    chk("coinc_loaded", {255'd0, loaded}, 256'd1);
    chk("coinc_image", {125'd0, shadow}, {125'd0, exp_img});

    // Edges while deselected are ignored.
    beat(1'b1);
    beat(1'b0);
    repeat (4) @(negedge clock);
    chk("desel_adv", adv_cnt, 256'd131);
    chk("desel_count", {248'd0, beat_count}, 256'd131);

    // Latency: advance visible after the 4th edge counting the sampling edge as the first.
    adv_cnt     = 0;
    exp_bits[0] = 1'b1;
    pin_sel_n   = 1'b0;
    repeat (4) @(negedge clock);
    pin_data = 1'b1;
    repeat (2) @(negedge clock);
    pin_sck = 1'b1;
    repeat (3) @(negedge clock);
    chk("lat_edge3", {255'd0, prog_advance}, 256'd0);
    @(negedge clock);
    chk("lat_edge4", {255'd0, prog_advance}, 256'd1);
    chk("lat_data", {255'd0, prog_data}, 256'd1);
    @(negedge clock);
    chk("lat_edge5", {255'd0, prog_advance}, 256'd0);
    chk("lat_count", {248'd0, beat_count}, 256'd1);
    pin_sck = 1'b0;
    repeat (3) @(negedge clock);

    // Reset mid-frame clears everything immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_enable", {255'd0, prog_enable}, 256'd0);
    chk("mid_rst_count", {248'd0, beat_count}, 256'd0);
    chk("mid_rst_data", {255'd0, prog_data}, 256'd0);
    chk("mid_rst_sel", {255'd0, dut.sel_n_s}, 256'd1);
    chk("mid_rst_state", {254'd0, dut.state_r}, {254'd0, ST_IDLE});
    pin_sel_n = 1'b1;
    @(negedge clock);
    rst_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("post_rst_state", {254'd0, dut.state_r}, {254'd0, ST_IDLE});
    chk("post_rst_run", {255'd0, run_enable}, 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
